// File: rtl/digit_seq_ctrl.sv
// digit_seq_ctrl
//   Converts one unsigned W-bit value per input handshake into two BCD digits
//   (tens, then units) using repeated subtract-by-10, and streams them over a
//   valid/ready port with first/last markers. W is legal from 1 to 6, so the
//   tens digit never exceeds 6.
//
//   Optional build macro MSD_SKIP_ZERO_EN: when defined, values below 10 emit
//   only the units digit, flagged as both first and last. When undefined,
//   every value emits exactly two digits and a zero tens digit is sent as '0'.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a value; in_ready high
//   S_DIV    | one subtract-by-10 per cycle until remainder < 10
//   S_EMIT_T | presenting tens digit (first), waiting for out_ready
//   S_EMIT_U | presenting units digit (last), waiting for out_ready

module digit_seq_ctrl #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_digit,
  output logic         out_first,
  output logic         out_last,
  output logic         busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIV    = 2'd1;
  localparam logic [1:0] S_EMIT_T = 2'd2;
  localparam logic [1:0] S_EMIT_U = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] rem_q, rem_d;
  logic [3:0]   tens_q, tens_d;

  // Remainder widened to 8 bits so the compare against 10 and the units
  // slice stay legal for every W from 1 to 6.
  logic [7:0]   rem_ext;
  logic         skip_tens;

  assign rem_ext = 8'(rem_q);

`ifdef MSD_SKIP_ZERO_EN
  assign skip_tens = (tens_q == 4'd0);
`else
  assign skip_tens = 1'b0;
`endif

  // Next-state and datapath update for the divide/emit sequence.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rem_d   = in_data;
          tens_d  = 4'd0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // Subtract only while rem >= 10, so rem never wraps.
        if (rem_ext >= 8'd10) begin
          rem_d  = rem_q - W'(10);
          tens_d = tens_q + 4'd1;
        end else if (skip_tens) begin
          state_d = S_EMIT_U;
        end else begin
          state_d = S_EMIT_T;
        end
      end
      S_EMIT_T: begin
        if (out_ready) state_d = S_EMIT_U;
      end
      S_EMIT_U: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      tens_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tens_q  <= tens_d;
    end
  end

  // Outputs depend on registered state only; all digit fields are zero
  // whenever out_valid is low.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_EMIT_T) || (state_q == S_EMIT_U);
    out_digit = 4'd0;
    out_first = 1'b0;
    out_last  = 1'b0;
    if (state_q == S_EMIT_T) begin
      out_digit = tens_q;
      out_first = 1'b1;
    end else if (state_q == S_EMIT_U) begin
      out_digit = rem_ext[3:0];
      out_first = skip_tens;
      out_last  = 1'b1;
    end
  end

endmodule

// File: tb/tb_digit_seq_ctrl.sv
// Bench for digit_seq_ctrl: a transaction-level model (value -> digit list,
// latency v/10+1) checked every cycle, plus directed literal expectations.
module tb_digit_seq_ctrl;
  localparam int W = 5;
`ifdef MSD_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_ready, out_first, out_last, busy;
  logic [3:0]   out_digit;
  logic         rdy_dir = 1'b1;
  logic         rdy_rand = 1'b1;
  logic         rand_mode = 1'b0;

  assign out_ready = rand_mode ? rdy_rand : rdy_dir;

  always #5 clk = ~clk;

  digit_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_digit(out_digit), .out_first(out_first), .out_last(out_last),
    .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // Model: a transaction holds its digit list and remaining wait cycles.
  int m_act = 0, m_wait = 0, m_idx = 0, m_nd = 2, m_d0 = 0, m_d1 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 0;
      m_idx <= 0;
    end else if (m_act == 0) begin
      if (in_valid) begin
        m_act  <= 1;
        m_wait <= int'(in_data) / 10 + 1;
        m_idx  <= 0;
        if (SKIP && int'(in_data) < 10) begin
          m_nd <= 1;
          m_d0 <= int'(in_data) % 10;
        end else begin
          m_nd <= 2;
          m_d0 <= int'(in_data) / 10;
          m_d1 <= int'(in_data) % 10;
        end
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (out_ready) begin
      if (m_idx + 1 == m_nd) m_act <= 0;
      m_idx <= m_idx + 1;
    end
  end

  logic       e_v, e_f, e_l;
  logic [3:0] e_d;
  assign e_v = (m_act != 0) && (m_wait == 0);
  assign e_d = e_v ? 4'((m_idx == 0) ? m_d0 : m_d1) : 4'd0;
  assign e_f = e_v && (m_idx == 0);
  assign e_l = e_v && (m_idx == m_nd - 1);

  // Every-cycle compare of {in_ready,busy,out_valid,first,last,digit}.
  always @(negedge clk)
    chk("cycle{rdy,busy,vld,first,last,digit}",
        int'({in_ready, busy, out_valid, out_first, out_last, out_digit}),
        int'({m_act == 0, m_act != 0, e_v, e_f, e_l, e_d}));

  // Digit handshake log.
  int rx_d[$], rx_f[$], rx_l[$];
  always @(posedge clk)
    if (rst_n && out_valid && out_ready) begin
      rx_d.push_back(int'(out_digit));
      rx_f.push_back(int'(out_first));
      rx_l.push_back(int'(out_last));
    end

  always @(negedge clk) rdy_rand <= 1'($urandom_range(0, 1));

  task automatic send(input int v);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = W'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_d.size() < n && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rx_count", rx_d.size(), n);
  endtask

  int base, lat;
  int exp_q[$];

  initial begin
    // 1: reset and idle
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_digit", out_digit, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
    end

    // 2: value 31
    base = rx_d.size();
    send(31);
    wait_valid(lat);
    chk("lat_31", lat, 4);
    wait_rx(base + 2);
    chk("v31_d0", rx_d[base], 3);
    chk("v31_f0", rx_f[base], 1);
    chk("v31_l0", rx_l[base], 0);
    chk("v31_d1", rx_d[base+1], 1);
    chk("v31_f1", rx_f[base+1], 0);
    chk("v31_l1", rx_l[base+1], 1);
    chk("v31_in_ready_after", in_ready, 1);

    // 3: values 10 and 0
    base = rx_d.size();
    send(10);
    wait_valid(lat);
    chk("lat_10", lat, 2);
    wait_rx(base + 2);
    chk("v10_d0", rx_d[base], 1);
    chk("v10_d1", rx_d[base+1], 0);
    base = rx_d.size();
    send(0);
    wait_valid(lat);
    chk("lat_0", lat, 1);
`ifdef MSD_SKIP_ZERO_EN
    wait_rx(base + 1);
    chk("v0_d", rx_d[base], 0);
    chk("v0_first", rx_f[base], 1);
    chk("v0_last", rx_l[base], 1);
    repeat (3) @(negedge clk);
    chk("v0_single", rx_d.size(), base + 1);
`else
    wait_rx(base + 2);
    chk("v0_d0", rx_d[base], 0);
    chk("v0_f0", rx_f[base], 1);
    chk("v0_d1", rx_d[base+1], 0);
    chk("v0_l1", rx_l[base+1], 1);
`endif

    // 4: value 27 under backpressure, in_valid held high meanwhile
    @(negedge clk);
    rdy_dir = 1'b0;
    base = rx_d.size();
    send(27);
    wait_valid(lat);
    chk("lat_27", lat, 3);
    in_valid = 1'b1;
    in_data  = W'(5);
    repeat (3) begin
      @(negedge clk);
      chk("bp_digit", out_digit, 2);
      chk("bp_first", out_first, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    rdy_dir  = 1'b1;
    in_valid = 1'b0;
    wait_rx(base + 2);
    chk("v27_d0", rx_d[base], 2);
    chk("v27_d1", rx_d[base+1], 7);
    repeat (4) @(negedge clk);
    chk("v27_once", rx_d.size(), base + 2);
    chk("v27_idle", busy, 0);

    // 5: reset during DIV, then value 9
    base = rx_d.size();
    send(25);
    @(posedge clk);
    #1;
    chk("div_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_no_digit", rx_d.size(), base);
    send(9);
    wait_valid(lat);
    chk("lat_9", lat, 1);
`ifdef MSD_SKIP_ZERO_EN
    wait_rx(base + 1);
    chk("v9_d", rx_d[base], 9);
    chk("v9_first", rx_f[base], 1);
    chk("v9_last", rx_l[base], 1);
`else
    wait_rx(base + 2);
    chk("v9_d0", rx_d[base], 0);
    chk("v9_d1", rx_d[base+1], 9);
`endif

    // 6: full sweep with random out_ready
    base = rx_d.size();
    rand_mode = 1'b1;
    for (int v = 0; v < (1 << W); v++) begin
      send(v);
      if (!(SKIP && v < 10)) exp_q.push_back(v / 10);
      exp_q.push_back(v % 10);
    end
    wait_rx(base + exp_q.size());
    rand_mode = 1'b0;
    for (int i = 0; i < exp_q.size(); i++)
      chk("sweep_digit", rx_d[base+i], exp_q[i]);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
